romcode_loader: RTL and testbench
=================================

Name: romcode_loader

Overview:
- Streams firmware words from a host AXI-Stream into the romcode BRAM, the BRAM that spiflash serves to caravel's flash port.
- Reads the image back and checks it against a running checksum.
- Holds caravel's resetb low until a verified image is present.
- Sits upstream of the romcode BRAM. The FPGA top muxes the BRAM port between this block and spiflash, using `busy` as the mux select.

Parameters:
- DEPTH_WORDS, 2048: BRAM capacity in 32-bit words. Power of two, at most 65536.
- RD_LAT, 1: BRAM read latency in cycles, 1 or 2.

Ports:
- ap_clk  in  1  single clock; also drives romcode_Clk_A.
- ap_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- s_axis_tdata  in  32  firmware word, little-endian, same format as counter_mm.hex.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tlast  in  1  marks the last image word.
- romcode_Addr_A  out  32  BRAM byte address, word aligned (index*4).
- romcode_EN_A  out  1  BRAM enable.
- romcode_WEN_A  out  4  byte write enables.
- romcode_Din_A  out  32  write data.
- romcode_Dout_A  in  32  read data.
- romcode_Clk_A  out  1  equals ap_clk.
- romcode_Rst_A  out  1  tied 0.
- busy  out  1  high in LOAD, VERIFY, WAIT; selects this block on the BRAM port mux.
- done  out  1  verified image present.
- error  out  1  load or verify failure.
- word_count  out  16  words accepted in the last load.
- soc_resetb  out  1  to caravel resetb; active-low.

Behaviour:
- Reset values (ap_rst low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including soc_resetb (0 means caravel is held in reset).
  - Address, count and checksum registers are cleared.
- States: IDLE, LOAD, VERIFY, WAIT, DONE, ERR.
- IDLE:
  - tready=0.
  - start → LOAD; clear the index, the checksum sum_w and word_count.
- LOAD:
  - tready=1 while index < DEPTH_WORDS.
  - A beat is accepted on tvalid&&tready.
  - Same cycle: EN_A=1, WEN_A=4'hF, Addr_A=index*4, Din_A=tdata.
  - Then: sum_w += tdata (mod 2^32), index++, word_count++.
  - Accepted beat with tlast=1 → VERIFY, with the read index reset to 0.
  - Accepted beat at index DEPTH_WORDS-1 without tlast → ERR (overflow). tready drops the next cycle.
  - tvalid low: no BRAM access (EN_A=0); remain in LOAD.
- VERIFY:
  - Issues one read per cycle: EN_A=1, WEN_A=0, Addr_A=rd_index*4, for rd_index 0..word_count-1.
  - Fully pipelined.
  - A valid-tag shift register of depth RD_LAT qualifies Dout_A.
  - Each qualified Dout_A is added to sum_r.
  - After the last read is issued → WAIT.
- WAIT:
  - Drains RD_LAT returns, with no new reads.
  - When the final qualified return has been added: sum_r==sum_w → DONE, else → ERR.
- DONE:
  - done=1, soc_resetb=1, busy=0, no BRAM access.
- ERR:
  - error=1, soc_resetb=0, busy=0.
- Re-arming:
  - start in DONE or ERR → LOAD. soc_resetb, done and error go to 0 in the same cycle start is registered; caravel re-enters reset.
  - start while busy is ignored.
  - start and a beat in the same cycle while in IDLE: the beat is not accepted (tready=0 in IDLE).
- Boundaries:
  - A single-word image (tlast on the first beat) is legal: 1 write, then 1 read.
  - An image of exactly DEPTH_WORDS with tlast on the last beat is legal.
  - word_count saturates at DEPTH_WORDS.
  - Reset asserted mid-LOAD or mid-VERIFY aborts immediately. Partial BRAM contents are undefined and soc_resetb stays 0.
- Latency:
  - N-word image: soc_resetb rises N_beats + N + RD_LAT + 1 cycles after the first accepted beat, with no stalls.

Decomposition:
- Shared package romcode_pkg holds:
  - the state enum;
  - ROM_WORD_W=32;
  - ADDR_STEP=4;
  - the default DEPTH_WORDS.
- One sub-module, romcode_rd_pipe: the RD_LAT valid-tag shift register plus the sum_r accumulator, with clear, issue and last-issued inputs and drained/sum outputs.

Test Plan:
- Load the 4 words 0x00000013, 0xDEADBEEF, 0x12345678, 0xAB610000 with tlast on word 4 → BRAM holds them at byte addresses 0, 4, 8, 12. word_count=4, done=1, soc_resetb=1, error=0.
- Same image with tvalid toggled every other cycle → identical BRAM contents and done=1. No BRAM write occurs in any cycle where tvalid=0.
- Force Dout_A bit 0 flipped on read index 2 → error=1, soc_resetb stays 0, done=0.
- DEPTH_WORDS=16, stream 17 words without tlast → ERR after word 16, tready=0 from the next cycle, word_count=16.
- Assert ap_rst for 1 cycle midway through VERIFY → all outputs 0 and state IDLE. A subsequent start plus a 1-word load of 0x0000006F → done=1.
- Run with RD_LAT=2 and a 2048-word ramp image (word i = i) → checksum 0x001FFC00 matches and done=1. Issue start from DONE → soc_resetb drops the next cycle.

Source files
------------

// File: rtl/romcode_pkg.sv
// Shared types and constants for the romcode loader: FSM states, word width,
// byte step per word and the default BRAM depth.
package romcode_pkg;
  localparam int ROM_WORD_W      = 32;
  localparam int ADDR_STEP       = 4;
  localparam int DEF_DEPTH_WORDS = 2048;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_VERIFY, S_WAIT, S_DONE, S_ERR
  } state_e;
endpackage

// File: rtl/romcode_rd_pipe.sv
// Read-return qualifier for the verify pass: RD_LAT-deep valid tags follow each
// issued read, qualified returns accumulate into sum_o.
module romcode_rd_pipe
  import romcode_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  issue_i,
  input  logic                  last_i,
  input  logic [ROM_WORD_W-1:0] dout_i,
  output logic                  drained_o,
  output logic [ROM_WORD_W-1:0] sum_o
);
  logic [RD_LAT-1:0]     vld_pipe_q, vld_pipe_d;
  logic                  last_seen_q;
  logic [ROM_WORD_W-1:0] sum_q;

  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = issue_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q  <= '0;
      last_seen_q <= 1'b0;
      sum_q       <= '0;
    end else if (clr_i) begin
      vld_pipe_q  <= '0;
      last_seen_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      if (vld_pipe_q[RD_LAT-1]) sum_q <= sum_q + dout_i;
      if (issue_i && last_i) last_seen_q <= 1'b1;
    end
  end

  // Drained once the final read was issued and its tag has left the pipe.
  assign drained_o = last_seen_q && (vld_pipe_q == '0);
  assign sum_o     = sum_q;
endmodule

// File: rtl/romcode_loader.sv
// Loads a firmware image from AXI-Stream into the romcode BRAM, reads it back
// against a running checksum and releases caravel reset only on a match.
module romcode_loader
  import romcode_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int RD_LAT      = 1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        start,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] romcode_Addr_A,
  output logic        romcode_EN_A,
  output logic [3:0]  romcode_WEN_A,
  output logic [31:0] romcode_Din_A,
  input  logic [31:0] romcode_Dout_A,
  output logic        romcode_Clk_A,
  output logic        romcode_Rst_A,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count,
  output logic        soc_resetb
);
  localparam int               IDX_W   = $clog2(DEPTH_WORDS) + 1;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [IDX_W-1:0] ONE_L   = IDX_W'(1);

  state_e                state_q;
  logic [IDX_W-1:0]      wr_idx_q, rd_idx_q, cnt_q;
  logic [ROM_WORD_W-1:0] sum_w_q, sum_r;
  logic                  busy_q, done_q, error_q, resetb_q;
  logic                  can_start, accept, rd_issue, rd_last, drained;

  // start is only honoured when not busy; a restart re-asserts caravel reset.
  assign can_start     = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign s_axis_tready = (state_q == S_LOAD) && (wr_idx_q < DEPTH_L);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign rd_issue      = (state_q == S_VERIFY);
  assign rd_last       = (rd_idx_q == cnt_q - ONE_L);

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_q  <= S_IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      sum_w_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      resetb_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (can_start) begin
            state_q  <= S_LOAD;
            wr_idx_q <= '0;
            cnt_q    <= '0;
            sum_w_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            resetb_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_idx_q <= wr_idx_q + ONE_L;
            sum_w_q  <= sum_w_q + s_axis_tdata;
            if (cnt_q != DEPTH_L) cnt_q <= cnt_q + ONE_L;
            if (s_axis_tlast) begin
              state_q  <= S_VERIFY;
              rd_idx_q <= '0;
            end else if (wr_idx_q == LAST_L) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
        end
        S_VERIFY: begin
          rd_idx_q <= rd_idx_q + ONE_L;
          if (rd_last) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (drained) begin
            busy_q <= 1'b0;
            if (sum_r == sum_w_q) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              resetb_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    romcode_EN_A   = 1'b0;
    romcode_WEN_A  = 4'h0;
    romcode_Addr_A = '0;
    romcode_Din_A  = '0;
    if (state_q == S_LOAD && accept) begin
      romcode_EN_A   = 1'b1;
      romcode_WEN_A  = 4'hF;
      romcode_Addr_A = 32'(wr_idx_q) * 32'(ADDR_STEP);
      romcode_Din_A  = s_axis_tdata;
    end else if (rd_issue) begin
      romcode_EN_A   = 1'b1;
      romcode_Addr_A = 32'(rd_idx_q) * 32'(ADDR_STEP);
    end
  end

  romcode_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk_i    (ap_clk),
    .rst_ni   (ap_rst),
    .clr_i    (can_start),
    .issue_i  (rd_issue),
    .last_i   (rd_last),
    .dout_i   (romcode_Dout_A),
    .drained_o(drained),
    .sum_o    (sum_r)
  );

  // A 65536-word image does not fit 16 bits; report it as all ones.
  assign word_count    = (32'(cnt_q) > 32'hFFFF) ? 16'hFFFF : 16'(cnt_q);
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign soc_resetb    = resetb_q;
  assign romcode_Clk_A = ap_clk;
  assign romcode_Rst_A = 1'b0;
endmodule

// File: tb/tb_romcode_loader.sv
// Bench for romcode_loader: a 2048-word RD_LAT=2 instance and a 16-word RD_LAT=1
// instance, each backed by a behavioural BRAM, selected by sel.
module tb_romcode_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, tvalid = 1'b0, tlast = 1'b0;
  logic        sel = 1'b0, corrupt = 1'b0;
  logic [31:0] tdata = '0;

  wire [1:0]        tready, en, clka, rsta, busy, done, error, resetb;
  wire [1:0][31:0]  addr, din, dout;
  wire [1:0][3:0]   wen;
  wire [1:0][15:0]  wc;

  int checks = 0, failures = 0, cyc_cnt = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t         sb[$];
  logic [31:0] img[$];
  logic [31:0] mem0 [2048];
  logic [31:0] mem1 [16];
  logic [31:0] q0a, q0b, q1a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  romcode_loader #(.DEPTH_WORDS(2048), .RD_LAT(2)) u_big (
    .ap_clk(clk), .ap_rst(rst_n), .start(start && !sel),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid && !sel), .s_axis_tready(tready[0]),
    .s_axis_tlast(tlast), .romcode_Addr_A(addr[0]), .romcode_EN_A(en[0]),
    .romcode_WEN_A(wen[0]), .romcode_Din_A(din[0]), .romcode_Dout_A(dout[0]),
    .romcode_Clk_A(clka[0]), .romcode_Rst_A(rsta[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .word_count(wc[0]), .soc_resetb(resetb[0]));

  romcode_loader #(.DEPTH_WORDS(16), .RD_LAT(1)) u_small (
    .ap_clk(clk), .ap_rst(rst_n), .start(start && sel),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid && sel), .s_axis_tready(tready[1]),
    .s_axis_tlast(tlast), .romcode_Addr_A(addr[1]), .romcode_EN_A(en[1]),
    .romcode_WEN_A(wen[1]), .romcode_Din_A(din[1]), .romcode_Dout_A(dout[1]),
    .romcode_Clk_A(clka[1]), .romcode_Rst_A(rsta[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .word_count(wc[1]), .soc_resetb(resetb[1]));

  // Behavioural BRAMs; corrupt flips bit 0 of the verify read at byte address 8.
  always @(posedge clk) begin
    if (en[0]) begin
      if (wen[0] == 4'hF) mem0[addr[0][12:2]] <= din[0];
      q0a <= mem0[addr[0][12:2]] ^ {31'd0, corrupt && wen[0] == 4'h0 && addr[0] == 32'd8};
    end
    q0b <= q0a;
    if (en[1]) begin
      if (wen[1] == 4'hF) mem1[addr[1][5:2]] <= din[1];
      q1a <= mem1[addr[1][5:2]];
    end
  end
  assign dout[0] = q0b;
  assign dout[1] = q1a;

  wire        v_tready = tready[sel], v_en = en[sel], v_busy = busy[sel];
  wire        v_done = done[sel], v_error = error[sel], v_resetb = resetb[sel];
  wire [3:0]  v_wen = wen[sel];
  wire [31:0] v_addr = addr[sel], v_din = din[sel];
  wire [15:0] v_wc = wc[sel];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Streams img; expected writes go on the scoreboard up front and are popped
  // as the DUT writes the BRAM. Stops when the DUT refuses a valid beat.
  task automatic send(input int depth, input bit toggle, input bit with_last,
                      output int acc, output int t0);
    int cyc = 0; bit ph = 0; bit acc_b; wr_t e;
    acc = 0; t0 = -1;
    for (int i = 0; i < img.size() && i < depth; i++) sb.push_back('{32'(i * 4), img[i]});
    while (acc < img.size() && cyc < 6000) begin
      tvalid = !(toggle && ph);
      tdata  = img[acc];
      tlast  = with_last && (acc == img.size() - 1);
      @(negedge clk);
      acc_b = tvalid && v_tready;
      if (acc_b && t0 < 0) t0 = cyc_cnt;
      if (v_en && v_wen != 4'h0) begin
        checks++;
        if (!tvalid || sb.size() == 0) begin
          failures++; $display("FAIL bram_write unexpected addr=%0h din=%0h tvalid=%0b", v_addr, v_din, tvalid);
        end else begin
          e = sb.pop_front();
          if (v_addr !== e.addr || v_din !== e.data || v_wen !== 4'hF) begin
            failures++;
            $display("FAIL bram_write got addr=%0h din=%0h wen=%0h exp addr=%0h din=%0h wen=f", v_addr, v_din, v_wen, e.addr, e.data);
          end
        end
      end
      if (tvalid && !v_tready) begin tick(); break; end
      tick(); cyc++; ph = !ph;
      if (acc_b) acc++;
    end
    tvalid = 1'b0; tlast = 1'b0;
    if (cyc >= 6000) begin checks++; failures++; $display("FAIL send_timeout acc=%0d", acc); end
  endtask

  task automatic wait_fin(output int rise);
    int n = 0;
    rise = -1;
    while (n < 10000) begin
      @(negedge clk);
      if (v_done || v_error) begin rise = cyc_cnt; break; end
      n++;
    end
    if (rise < 0) begin checks++; failures++; $display("FAIL wait_fin timeout got=none exp=done_or_error"); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, error, resetb, en, tready} !== '0) begin
      failures++; $display("FAIL reset_status got=%0h exp=0", {busy, done, error, resetb, en, tready});
    end
    checks++;
    if ({wc[0], wc[1], wen[0], wen[1], addr[0], addr[1], din[0], din[1]} !== '0) begin
      failures++; $display("FAIL reset_bram_wc got wc0=%0h wc1=%0h addr0=%0h exp=0", wc[0], wc[1], addr[0]);
    end
  endtask

  task automatic test_basic();
    int acc, t0, rise;
    sel = 1'b0;
    img = '{32'h00000013, 32'hDEADBEEF, 32'h12345678, 32'hAB610000};
    pulse_start();
    checks++; if (v_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", v_busy); end
    send(2048, 0, 1, acc, t0);
    wait_fin(rise);
    checks++; if (v_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", v_done); end
    checks++; if (v_error !== 1'b0) begin failures++; $display("FAIL basic_error got=%0b exp=0", v_error); end
    checks++; if (v_resetb !== 1'b1) begin failures++; $display("FAIL basic_resetb got=%0b exp=1", v_resetb); end
    checks++; if (v_wc !== 16'd4) begin failures++; $display("FAIL basic_wc got=%0d exp=4", v_wc); end
    checks++; if (rise - t0 != 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", rise - t0); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_sb_left got=%0d exp=0", sb.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem0[i] !== img[i]) begin failures++; $display("FAIL basic_mem[%0d] got=%0h exp=%0h", i, mem0[i], img[i]); end
    end
  endtask

  task automatic test_toggle();
    int acc, t0, rise;
    sel = 1'b0;
    pulse_start();
    send(2048, 1, 1, acc, t0);
    wait_fin(rise);
    checks++; if (v_done !== 1'b1) begin failures++; $display("FAIL toggle_done got=%0b exp=1", v_done); end
    checks++; if (v_wc !== 16'd4) begin failures++; $display("FAIL toggle_wc got=%0d exp=4", v_wc); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL toggle_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_corrupt();
    int acc, t0, rise;
    sel = 1'b0; corrupt = 1'b1;
    pulse_start();
    send(2048, 0, 1, acc, t0);
    wait_fin(rise);
    corrupt = 1'b0;
    checks++; if (v_error !== 1'b1) begin failures++; $display("FAIL corrupt_error got=%0b exp=1", v_error); end
    checks++; if (v_resetb !== 1'b0) begin failures++; $display("FAIL corrupt_resetb got=%0b exp=0", v_resetb); end
    checks++; if (v_done !== 1'b0) begin failures++; $display("FAIL corrupt_done got=%0b exp=0", v_done); end
  endtask

  task automatic test_rdlat1();
    int acc, t0, rise;
    sel = 1'b1;
    img = '{32'hCAFEF00D, 32'h00000001};
    pulse_start();
    send(16, 0, 1, acc, t0);
    wait_fin(rise);
    checks++; if (v_done !== 1'b1) begin failures++; $display("FAIL rdlat1_done got=%0b exp=1", v_done); end
    checks++; if (rise - t0 != 6) begin failures++; $display("FAIL rdlat1_latency got=%0d exp=6", rise - t0); end
    checks++;
    if (mem1[0] !== 32'hCAFEF00D || mem1[1] !== 32'h1) begin
      failures++; $display("FAIL rdlat1_mem got=%0h,%0h exp=cafef00d,1", mem1[0], mem1[1]);
    end
  endtask

  task automatic test_overflow();
    int acc, t0;
    sel = 1'b1;
    img.delete();
    for (int i = 0; i < 17; i++) img.push_back(32'(i + 100));
    pulse_start();
    send(16, 0, 0, acc, t0);
    @(negedge clk);
    checks++; if (acc != 16) begin failures++; $display("FAIL ovf_accepted got=%0d exp=16", acc); end
    checks++; if (v_tready !== 1'b0) begin failures++; $display("FAIL ovf_tready got=%0b exp=0", v_tready); end
    checks++; if (v_error !== 1'b1) begin failures++; $display("FAIL ovf_error got=%0b exp=1", v_error); end
    checks++; if (v_wc !== 16'd16) begin failures++; $display("FAIL ovf_wc got=%0d exp=16", v_wc); end
    checks++; if (v_resetb !== 1'b0) begin failures++; $display("FAIL ovf_resetb got=%0b exp=0", v_resetb); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovf_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid_verify();
    int acc, t0, rise;
    sel = 1'b0;
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(32'(i * 3 + 1));
    pulse_start();
    send(2048, 0, 1, acc, t0);
    tick(); tick();
    rst_n = 1'b0; #1;
    checks++;
    if ({v_busy, v_done, v_error, v_resetb, v_en} !== 5'b0 || v_wc !== 16'd0) begin
      failures++; $display("FAIL midrst_outputs got=%0b wc=%0d exp=0", {v_busy, v_done, v_error, v_resetb, v_en}, v_wc);
    end
    tick(); rst_n = 1'b1; tick();
    start = 1'b1; tvalid = 1'b1; tdata = 32'h0000006F; tlast = 1'b1;
    @(negedge clk);
    checks++;
    if (v_tready !== 1'b0 || v_en !== 1'b0 || v_busy !== 1'b0) begin
      failures++; $display("FAIL idle_start_beat got tready=%0b en=%0b busy=%0b exp=0", v_tready, v_en, v_busy);
    end
    tick();
    start = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    img = '{32'h0000006F};
    send(2048, 0, 1, acc, t0);
    wait_fin(rise);
    checks++; if (v_done !== 1'b1) begin failures++; $display("FAIL midrst_reload_done got=%0b exp=1", v_done); end
    checks++; if (v_wc !== 16'd1) begin failures++; $display("FAIL midrst_reload_wc got=%0d exp=1", v_wc); end
  endtask

  task automatic test_ramp_rearm();
    int acc, t0, rise;
    logic [31:0] sum;
    sel = 1'b0;
    img.delete();
    for (int i = 0; i < 2048; i++) img.push_back(32'(i));
    pulse_start();
    send(2048, 0, 1, acc, t0);
    wait_fin(rise);
    sum = '0;
    for (int i = 0; i < 2048; i++) sum = sum + mem0[i];
    checks++; if (v_done !== 1'b1) begin failures++; $display("FAIL ramp_done got=%0b exp=1", v_done); end
    checks++; if (v_wc !== 16'd2048) begin failures++; $display("FAIL ramp_wc got=%0d exp=2048", v_wc); end
    checks++; if (sum !== 32'h001FFC00) begin failures++; $display("FAIL ramp_sum got=%0h exp=1ffc00", sum); end
    checks++; if (rise - t0 != 4099) begin failures++; $display("FAIL ramp_latency got=%0d exp=4099", rise - t0); end
    pulse_start();
    checks++;
    if (v_resetb !== 1'b0 || v_done !== 1'b0 || v_busy !== 1'b1) begin
      failures++; $display("FAIL rearm got resetb=%0b done=%0b busy=%0b exp=0,0,1", v_resetb, v_done, v_busy);
    end
  endtask

  task automatic test_back_to_back();
    int acc, t0, rise;
    sel = 1'b0;
    img = '{32'h11111111, 32'h22222222, 32'h33333333};
    send(2048, 0, 1, acc, t0);
    pulse_start();
    wait_fin(rise);
    checks++; if (v_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b exp=1", v_done); end
    checks++; if (v_wc !== 16'd3) begin failures++; $display("FAIL b2b_wc got=%0d exp=3", v_wc); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_toggle();
    test_corrupt();
    test_rdlat1();
    test_overflow();
    test_reset_mid_verify();
    test_ramp_rearm();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
endmodule
